// File: rtl/uart_inst_rx.sv
// UART 8N1 receive front end: turns serial bytes on RsRx into instruction
// words with a one-cycle valid strobe, flagging bad stop bits as framing errors.
module uart_inst_rx #(
  parameter int unsigned CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RsRx,
  output logic [7:0] inst_wd,
  output logic       inst_vld,
  output logic       frm_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned DAT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state, state_nxt;
  logic               rx_meta, rx_s;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [DAT_W-1:0]   sh, sh_nxt;
  logic [DAT_W-1:0]   wd_nxt;
  logic               vld_nxt, err_nxt;
  logic               half_done, bit_done;

  assign half_done = (cnt == CNT_W'(HALF - 1));
  assign bit_done  = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RsRx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      inst_wd  <= '0;
      inst_vld <= 1'b0;
      frm_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      sh       <= sh_nxt;
      inst_wd  <= wd_nxt;
      inst_vld <= vld_nxt;
      frm_err  <= err_nxt;
      busy     <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    wd_nxt    = inst_wd;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;

    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = S_START;
      end

      // Re-check the line mid start bit to reject short glitches.
      S_START: begin
        if (half_done) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s, sh[DAT_W-1:1]};
          if (idx == IDX_W'(DAT_W - 1)) begin
            state_nxt = S_STOP;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          cnt_nxt = '0;
          if (rx_s) begin
            wd_nxt    = sh;
            vld_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_BREAK;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      // A line held low after a bad stop bit must not look like a new start.
      S_BREAK: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_inst_rx.sv
// Bench for uart_inst_rx: directed frames; a cycle-indexed schedule of expected
// pulses, busy windows and words is checked against the DUT every cycle.
module tb_uart_inst_rx;

  localparam int N    = 100;
  localparam int H    = N / 2;
  localparam int LAT  = 2 + H + 9 * N + 1;
  localparam int MAXC = 25000;

  logic       clk = 1'b0;
  logic       rst;
  logic       rsrx;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       frm_err;
  logic       busy;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int last_vld_cyc = 0;
  bit chk_en = 1'b0;

  bit         exp_vld  [MAXC];
  bit         exp_err  [MAXC];
  bit         exp_busy [MAXC];
  bit         wd_reset [MAXC];
  logic [7:0] exp_byte [MAXC];
  logic [7:0] model_wd = 8'h00;

  uart_inst_rx #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .RsRx     (rsrx),
    .inst_wd  (inst_wd),
    .inst_vld (inst_vld),
    .frm_err  (frm_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the expected schedule.
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      if (wd_reset[cyc]) model_wd = 8'h00;
      if (exp_vld[cyc]) model_wd = exp_byte[cyc];
      check("inst_vld", 32'(inst_vld), 32'(exp_vld[cyc]));
      check("frm_err", 32'(frm_err), 32'(exp_err[cyc]));
      check("busy", 32'(busy), 32'(exp_busy[cyc]));
      check("inst_wd", 32'(inst_wd), 32'(model_wd));
      if (inst_vld === 1'b1) begin
        vld_cnt++;
        last_vld_cyc = cyc;
      end
      if (frm_err === 1'b1) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_busy(input int from, input int upto);
    for (int i = from; i <= upto; i++) if (i < MAXC) exp_busy[i] = 1'b1;
  endtask

  // Drives one frame starting this cycle; optionally schedules its good-byte outcome.
  task automatic send_frame(input logic [7:0] b, input int t, input bit stop, input bit expect_it);
    int r;
    r = cyc;
    if (expect_it) begin
      exp_vld[r + LAT]  = 1'b1;
      exp_byte[r + LAT] = b;
      set_busy(r + 3, r + LAT - 1);
    end
    rsrx = 1'b0;
    repeat (t) tick();
    for (int k = 0; k < 8; k++) begin
      rsrx = b[k];
      repeat (t) tick();
    end
    rsrx = stop;
    repeat (t) tick();
  endtask

  initial begin
    int r;
    int c;
    logic [7:0] b2b [6];
    b2b[0] = 8'h34; b2b[1] = 8'h00; b2b[2] = 8'h13;
    b2b[3] = 8'h86; b2b[4] = 8'h4C; b2b[5] = 8'hC0;

    rst  = 1'b1;
    rsrx = 1'b1;
    repeat (4) tick();
    check("reset_wd", 32'(inst_wd), 32'h00);
    check("reset_vld", 32'(inst_vld), 32'h0);
    check("reset_err", 32'(frm_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (10) tick();

    // Single byte and its latency from the start edge.
    r = cyc;
    send_frame(8'h34, N, 1'b1, 1'b1);
    repeat (100) tick();
    check("single_wd", 32'(inst_wd), 32'h34);
    check("single_latency", 32'(last_vld_cyc - r), 32'd953);
    check("single_count", 32'(vld_cnt), 32'd1);

    // Back-to-back frames with no idle gap.
    for (int i = 0; i < 6; i++) send_frame(b2b[i], N, 1'b1, 1'b1);
    repeat (100) tick();
    check("b2b_wd", 32'(inst_wd), 32'hC0);
    check("b2b_count", 32'(vld_cnt), 32'd7);

    // Glitch shorter than half a bit.
    r = cyc;
    set_busy(r + 3, r + 2 + H);
    rsrx = 1'b0;
    repeat (30) tick();
    rsrx = 1'b1;
    repeat (100) tick();
    check("glitch_wd", 32'(inst_wd), 32'hC0);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_count", 32'(vld_cnt), 32'd7);

    // Framing error, line held low, then a good byte.
    r = cyc;
    exp_err[r + LAT] = 1'b1;
    set_busy(r + 3, r + 10 * N + 500 + 2);
    send_frame(8'hA5, N, 1'b0, 1'b0);
    repeat (500) tick();
    rsrx = 1'b1;
    repeat (20) tick();
    check("ferr_count", 32'(err_cnt), 32'd1);
    check("ferr_wd_held", 32'(inst_wd), 32'hC0);
    check("ferr_vld_count", 32'(vld_cnt), 32'd7);
    send_frame(8'h5A, N, 1'b1, 1'b1);
    repeat (100) tick();
    check("after_ferr_wd", 32'(inst_wd), 32'h5A);

    // Reset during data bit 4 of 0xFF.
    r = cyc;
    c = r + 5 * N + 30;
    set_busy(r + 3, c);
    wd_reset[c + 1] = 1'b1;
    fork
      send_frame(8'hFF, N, 1'b1, 1'b0);
      begin
        repeat (5 * N + 30) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
      end
    join
    repeat (20) tick();
    check("midrst_wd", 32'(inst_wd), 32'h00);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_count", 32'(vld_cnt), 32'd8);
    send_frame(8'h12, N, 1'b1, 1'b1);
    repeat (100) tick();
    check("post_rst_wd", 32'(inst_wd), 32'h12);

    // Transmitter baud offset of +/-4%.
    send_frame(8'h55, 104, 1'b1, 1'b1);
    repeat (50) tick();
    send_frame(8'hAA, 104, 1'b1, 1'b1);
    repeat (50) tick();
    check("baud104_wd", 32'(inst_wd), 32'hAA);
    send_frame(8'h55, 96, 1'b1, 1'b1);
    repeat (50) tick();
    check("baud96_wd", 32'(inst_wd), 32'h55);
    send_frame(8'hAA, 96, 1'b1, 1'b1);
    repeat (1100) tick();
    check("final_wd", 32'(inst_wd), 32'hAA);
    check("final_vld_count", 32'(vld_cnt), 32'd13);
    check("final_err_count", 32'(err_cnt), 32'd1);
    check("cycle_budget", 32'(cyc < MAXC), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
